// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing with memory-ready stalls.
// Optional build macro ILLEGAL_TRAP_EN: unlisted opcodes trap in TRAP (else they retire as a NOP).
module multicycle_control #(
   parameter int unsigned ALUOP_W = 2,
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic [1:0]         pc_source,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               instr_done,
   output logic [STATE_W-1:0] state,
   output logic               illegal_op
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

   state_t              r_state;
   state_t              w_next;
   logic                w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
   logic                w_ir_write, w_mem_to_reg, w_alu_src_a, w_reg_write, w_reg_dst;
   logic                w_instr_done, w_illegal;
   logic [1:0]          w_pc_source, w_alu_src_b;
   logic [ALUOP_W-1:0]  w_alu_op;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // Next-state and Moore outputs (mem_ready qualifies fetch load and store retire)
   always_comb begin
      w_next          = r_state;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_i_or_d        = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_pc_source     = 2'd0;
      w_alu_op        = ALU_ADD;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = 2'd0;
      w_reg_write     = 1'b0;
      w_reg_dst       = 1'b0;
      w_instr_done    = 1'b0;
      w_illegal       = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = 2'd1;
            w_ir_write  = mem_ready;
            w_pc_write  = mem_ready;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            w_alu_src_b = 2'd3;
            case (opcode)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXEC;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  w_next = S_TRAP;
`else
                  w_instr_done = 1'b1;
                  w_next       = S_FETCH;
`endif
               end
            endcase
         end
         S_MEMADR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'd2;
            w_next      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_mem_read = 1'b1;
            w_i_or_d   = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
            w_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEMWR: begin
            w_mem_write  = 1'b1;
            w_i_or_d     = 1'b1;
            w_instr_done = mem_ready;
            if (mem_ready) w_next = S_FETCH;
         end
         S_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALU_FUNCT;
            w_next      = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write  = 1'b1;
            w_reg_dst    = 1'b1;
            w_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_src_a     = 1'b1;
            w_alu_op        = ALU_SUB;
            w_pc_write_cond = 1'b1;
            w_pc_source     = 2'd1;
            w_instr_done    = 1'b1;
            w_next          = S_FETCH;
         end
         S_ADDIEX: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'd2;
            w_next      = S_ADDIWB;
         end
         S_ADDIWB: begin
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_JUMP: begin
            w_pc_write   = 1'b1;
            w_pc_source  = 2'd2;
            w_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: w_illegal = 1'b1;
`endif
         default: w_next = S_FETCH;
      endcase
   end

   // Outputs forced low while reset is held so no partial write escapes
   assign pc_write      = rst_n & w_pc_write;
   assign pc_write_cond = rst_n & w_pc_write_cond;
   assign i_or_d        = rst_n & w_i_or_d;
   assign mem_read      = rst_n & w_mem_read;
   assign mem_write     = rst_n & w_mem_write;
   assign ir_write      = rst_n & w_ir_write;
   assign mem_to_reg    = rst_n & w_mem_to_reg;
   assign pc_source     = rst_n ? w_pc_source : 2'd0;
   assign alu_op        = rst_n ? w_alu_op : ALU_ADD;
   assign alu_src_a     = rst_n & w_alu_src_a;
   assign alu_src_b     = rst_n ? w_alu_src_b : 2'd0;
   assign reg_write     = rst_n & w_reg_write;
   assign reg_dst       = rst_n & w_reg_dst;
   assign instr_done    = rst_n & w_instr_done;
   assign illegal_op    = rst_n & w_illegal;
   assign state         = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (honours ILLEGAL_TRAP_EN when defined).
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
   logic [1:0] pc_source, alu_src_b;
   logic [1:0] alu_op;
   logic       alu_src_a, reg_write, reg_dst, instr_done, illegal_op;
   logic [3:0] state;

   int unsigned errors = 0;
   int unsigned checks = 0;

   multicycle_control #(.ALUOP_W(2), .STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .pc_source(pc_source), .alu_op(alu_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
      .reg_dst(reg_dst), .instr_done(instr_done), .state(state), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      opcode    = 6'h00;
      #12;
      chk("rst_state",    32'(state), 0);
      chk("rst_mem_read", 32'(mem_read), 0);
      chk("rst_ir_write", 32'(ir_write), 0);
      chk("rst_alu_srcb", 32'(alu_src_b), 0);
      chk("rst_illegal",  32'(illegal_op), 0);

      // R-type: 0,1,6,7,0
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("r_fetch_state", 32'(state), 0);
      chk("r_fetch_mrd",   32'(mem_read), 1);
      chk("r_fetch_irw",   32'(ir_write), 1);
      chk("r_fetch_pcw",   32'(pc_write), 1);
      chk("r_fetch_srcb",  32'(alu_src_b), 1);
      step();
      chk("r_dec_state", 32'(state), 1);
      chk("r_dec_srcb",  32'(alu_src_b), 3);
      chk("r_dec_done",  32'(instr_done), 0);
      step();
      chk("r_exec_state", 32'(state), 6);
      chk("r_exec_aluop", 32'(alu_op), 2);
      chk("r_exec_srca",  32'(alu_src_a), 1);
      chk("r_exec_srcb",  32'(alu_src_b), 0);
      step();
      chk("r_wb_state", 32'(state), 7);
      chk("r_wb_regw",  32'(reg_write), 1);
      chk("r_wb_dst",   32'(reg_dst), 1);
      chk("r_wb_done",  32'(instr_done), 1);
      step();
      chk("r_end_state", 32'(state), 0);

      // lw with a fetch stall and two MEMRD stalls
      opcode    = 6'h23;
      mem_ready = 1'b0;
      #1;
      chk("lw_fstall_irw", 32'(ir_write), 0);
      chk("lw_fstall_pcw", 32'(pc_write), 0);
      step();
      chk("lw_fstall_state", 32'(state), 0);
      mem_ready = 1'b1;
      #1;
      chk("lw_fetch_irw", 32'(ir_write), 1);
      step();
      chk("lw_dec_state", 32'(state), 1);
      step();
      chk("lw_madr_state", 32'(state), 2);
      chk("lw_madr_srcb",  32'(alu_src_b), 2);
      chk("lw_madr_srca",  32'(alu_src_a), 1);
      step();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) mem_ready = 1'b1;
         #1;
         chk("lw_mrd_state", 32'(state), 3);
         chk("lw_mrd_mrd",   32'(mem_read), 1);
         chk("lw_mrd_iord",  32'(i_or_d), 1);
         chk("lw_mrd_done",  32'(instr_done), 0);
         step();
      end
      chk("lw_wb_state", 32'(state), 4);
      chk("lw_wb_m2r",   32'(mem_to_reg), 1);
      chk("lw_wb_regw",  32'(reg_write), 1);
      chk("lw_wb_dst",   32'(reg_dst), 0);
      chk("lw_wb_done",  32'(instr_done), 1);
      step();
      chk("lw_end_state", 32'(state), 0);

      // sw: 0,1,2,5,0
      opcode = 6'h2B;
      step();
      step();
      chk("sw_madr_state", 32'(state), 2);
      chk("sw_madr_regw",  32'(reg_write), 0);
      step();
      chk("sw_mwr_state", 32'(state), 5);
      chk("sw_mwr_mwr",   32'(mem_write), 1);
      chk("sw_mwr_mrd",   32'(mem_read), 0);
      chk("sw_mwr_done",  32'(instr_done), 1);
      chk("sw_mwr_regw",  32'(reg_write), 0);
      step();
      chk("sw_end_state", 32'(state), 0);
      chk("sw_end_mwr",   32'(mem_write), 0);

      // beq then j
      opcode = 6'h04;
      step();
      step();
      chk("beq_state", 32'(state), 8);
      chk("beq_pwc",   32'(pc_write_cond), 1);
      chk("beq_psrc",  32'(pc_source), 1);
      chk("beq_aluop", 32'(alu_op), 1);
      chk("beq_done",  32'(instr_done), 1);
      step();
      chk("beq_end", 32'(state), 0);
      opcode = 6'h02;
      step();
      step();
      chk("j_state", 32'(state), 11);
      chk("j_pcw",   32'(pc_write), 1);
      chk("j_psrc",  32'(pc_source), 2);
      chk("j_done",  32'(instr_done), 1);
      step();
      chk("j_end", 32'(state), 0);

      // addi: 0,1,9,10,0
      opcode = 6'h08;
      step();
      step();
      chk("addi_ex_state", 32'(state), 9);
      chk("addi_ex_srcb",  32'(alu_src_b), 2);
      step();
      chk("addi_wb_state", 32'(state), 10);
      chk("addi_wb_regw",  32'(reg_write), 1);
      chk("addi_wb_dst",   32'(reg_dst), 0);
      step();
      chk("addi_end", 32'(state), 0);

      // Asynchronous reset while a store is stalled
      opcode = 6'h2B;
      step();
      step();
      step();
      mem_ready = 1'b0;
      #1;
      chk("arst_pre_state", 32'(state), 5);
      chk("arst_pre_mwr",   32'(mem_write), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(state), 0);
      chk("arst_mwr",   32'(mem_write), 0);
      chk("arst_iord",  32'(i_or_d), 0);
      mem_ready = 1'b1;
      opcode    = 6'h00;
      step();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("arst_post_mwr", 32'(mem_write), 0);
         step();
      end
      chk("arst_post_state", 32'(state), 0);

      // Unlisted opcode
      opcode = 6'h3F;
      step();
      chk("ill_dec_state", 32'(state), 1);
`ifdef ILLEGAL_TRAP_EN
      chk("ill_dec_done", 32'(instr_done), 0);
      step();
      for (int i = 0; i < 10; i++) begin
         chk("ill_trap_state", 32'(state), 12);
         chk("ill_trap_flag",  32'(illegal_op), 1);
         chk("ill_trap_mrd",   32'(mem_read), 0);
         step();
      end
      rst_n = 1'b0;
      #1;
      chk("ill_rst_state", 32'(state), 0);
      chk("ill_rst_flag",  32'(illegal_op), 0);
`else
      chk("ill_dec_done", 32'(instr_done), 1);
      chk("ill_dec_flag", 32'(illegal_op), 0);
      step();
      chk("ill_end_state", 32'(state), 0);
      chk("ill_end_flag",  32'(illegal_op), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
